// File: rtl/rr_sched_arbiter.sv
// Round-robin arbiter with registered one-hot grants and an optional lock mode.
// The grant is held until the winner acknowledges or drops its request.

module rr_sched_arbiter_penc #(
  parameter int W       = 4,
  parameter int IW      = 2,
  parameter bit REVERSE = 1'b1
) (
  input  logic [W-1:0]  req_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);
  // REVERSE=1: the lowest set bit wins. Only indices below W can ever be produced.
  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    if (REVERSE) begin
      for (int i = W - 1; i >= 0; i--)
        if (req_i[i]) idx_o = IW'(i);
    end else begin
      for (int i = 0; i < W; i++)
        if (req_i[i]) idx_o = IW'(i);
    end
  end
endmodule

module rr_sched_arbiter #(
  parameter int PORTS   = 4,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);
  localparam int IW = $clog2(PORTS);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]    enc_q, enc_d;

  logic [PORTS-1:0] masked_req;
  logic             m_vld, a_vld;
  logic [IW-1:0]    m_idx, a_idx, winner;
  logic             any_req, release_now;
  logic [PORTS-1:0] win_onehot, win_mask;

  assign masked_req = request & mask_q;

  rr_sched_arbiter_penc #(.W(PORTS), .IW(IW), .REVERSE(1'b1)) u_enc_masked (
    .req_i (masked_req),
    .vld_o (m_vld),
    .idx_o (m_idx)
  );

  rr_sched_arbiter_penc #(.W(PORTS), .IW(IW), .REVERSE(1'b1)) u_enc_all (
    .req_i (request),
    .vld_o (a_vld),
    .idx_o (a_idx)
  );

  assign winner      = m_vld ? m_idx : a_idx;
  assign any_req     = a_vld;
  assign release_now = acknowledge[enc_q] | ~request[enc_q];

  // Mask keeps only ports strictly above the winner; empty after the top port.
  always_comb begin
    win_onehot = '0;
    win_mask   = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      win_onehot[i] = (i == 32'(winner));
      win_mask[i]   = (i >  32'(winner));
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    grant_d = grant_q;
    enc_d   = enc_q;
    if (!LOCK_EN) begin
      state_d = ST_IDLE;
      grant_d = '0;
      enc_d   = '0;
      if (any_req) begin
        grant_d = win_onehot;
        enc_d   = winner;
        mask_d  = win_mask;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_d = win_onehot;
            enc_d   = winner;
            mask_d  = win_mask;
            state_d = ST_GRANT;
          end
        end
        default: begin
          if (release_now) begin
            grant_d = '0;
            enc_d   = '0;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '1;
      grant_q <= '0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = |grant_q;
  assign grant_encoded = enc_q;
endmodule

// File: tb/tb_rr_sched_arbiter.sv
// Directed bench for rr_sched_arbiter: free-running and locked 4-port arbiters
// plus a 5-port free-running arbiter, sharing clock and reset.

module tb_rr_sched_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req0 = '0, ack0 = '0, gnt0;
  logic       vld0;
  logic [1:0] enc0;
  logic [3:0] req1 = '0, ack1 = '0, gnt1;
  logic       vld1;
  logic [1:0] enc1;
  logic [4:0] req2 = '0, ack2 = '0, gnt2;
  logic       vld2;
  logic [2:0] enc2;

  rr_sched_arbiter #(.PORTS(4), .LOCK_EN(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .request(req0), .acknowledge(ack0),
    .grant(gnt0), .grant_valid(vld0), .grant_encoded(enc0));
  rr_sched_arbiter #(.PORTS(4), .LOCK_EN(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .request(req1), .acknowledge(ack1),
    .grant(gnt1), .grant_valid(vld1), .grant_encoded(enc1));
  rr_sched_arbiter #(.PORTS(5), .LOCK_EN(1'b0)) d2 (
    .clk(clk), .rst_n(rst_n), .request(req2), .acknowledge(ack2),
    .grant(gnt2), .grant_valid(vld2), .grant_encoded(enc2));

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] enc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Structural invariants on every DUT, sampled away from the active edge.
  always @(negedge clk) begin
    chk("inv0_onehot", 32'($onehot0(gnt0)), 32'd1);
    chk("inv0_valid",  32'(vld0), 32'(|gnt0));
    if (vld0) chk("inv0_enc", 32'(gnt0[enc0]), 32'd1);
    chk("inv1_onehot", 32'($onehot0(gnt1)), 32'd1);
    chk("inv1_valid",  32'(vld1), 32'(|gnt1));
    if (vld1) chk("inv1_enc", 32'(gnt1[enc1]), 32'd1);
    chk("inv2_onehot", 32'($onehot0(gnt2)), 32'd1);
    chk("inv2_valid",  32'(vld2), 32'(|gnt2));
    if (vld2) chk("inv2_range", 32'(enc2 <= 3'd4), 32'd1);
  end

  vec_t v0[9];
  vec_t v1[13];

  initial begin
    // Free-running: full rotation, then wrap via empty mask, idle, resume.
    v0[0] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
    v0[1] = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1};
    v0[2] = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2};
    v0[3] = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3};
    v0[4] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
    v0[5] = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3};
    v0[6] = '{4'b1001, 4'b0000, 4'b0001, 1'b1, 2'd0};
    v0[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    v0[8] = '{4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1};
    // Locked: hold 3 cycles, foreign ack ignored, bubble, drop-release,
    // next-above winner, wrap, same-cycle ack.
    v1[0]  = '{4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1};
    v1[1]  = '{4'b0110, 4'b0100, 4'b0010, 1'b1, 2'd1};
    v1[2]  = '{4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1};
    v1[3]  = '{4'b0110, 4'b0010, 4'b0000, 1'b0, 2'd0};
    v1[4]  = '{4'b0110, 4'b0000, 4'b0100, 1'b1, 2'd2};
    v1[5]  = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0};
    v1[6]  = '{4'b1010, 4'b0000, 4'b1000, 1'b1, 2'd3};
    v1[7]  = '{4'b1011, 4'b0000, 4'b1000, 1'b1, 2'd3};
    v1[8]  = '{4'b1011, 4'b1000, 4'b0000, 1'b0, 2'd0};
    v1[9]  = '{4'b1001, 4'b0000, 4'b0001, 1'b1, 2'd0};
    v1[10] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0};
    v1[11] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
    v1[12] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};

    #2;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_vld0", 32'(vld0), 32'd0);
    chk("rst_enc0", 32'(enc0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_vld1", 32'(vld1), 32'd0);
    chk("rst_gnt2", 32'(gnt2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_gnt0", 32'(gnt0), 32'd0);

    for (int i = 0; i < 9; i++) begin
      req0 = v0[i].req; ack0 = v0[i].ack;
      @(posedge clk); #1;
      chk($sformatf("v0[%0d].gnt", i), 32'(gnt0), 32'(v0[i].gnt));
      chk($sformatf("v0[%0d].vld", i), 32'(vld0), 32'(v0[i].vld));
      if (v0[i].vld) chk($sformatf("v0[%0d].enc", i), 32'(enc0), 32'(v0[i].enc));
    end
    req0 = '0;

    for (int i = 0; i < 13; i++) begin
      req1 = v1[i].req; ack1 = v1[i].ack;
      @(posedge clk); #1;
      chk($sformatf("v1[%0d].gnt", i), 32'(gnt1), 32'(v1[i].gnt));
      chk($sformatf("v1[%0d].vld", i), 32'(vld1), 32'(v1[i].vld));
      if (v1[i].vld) chk($sformatf("v1[%0d].enc", i), 32'(enc1), 32'(v1[i].enc));
    end

    // 5 ports: ports 0 and 4 alternate; index 4 wraps through the empty mask.
    req2 = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("p5[%0d].gnt", i), 32'(gnt2), (i % 2 == 0) ? 32'h01 : 32'h10);
      chk($sformatf("p5[%0d].enc", i), 32'(enc2), (i % 2 == 0) ? 32'd0 : 32'd4);
    end
    req2 = '0;

    // Asynchronous reset while d1 holds port 2.
    chk("pre_rst_gnt1", 32'(gnt1), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt1", 32'(gnt1), 32'd0);
    chk("arst_vld1", 32'(vld1), 32'd0);
    chk("arst_enc1", 32'(enc1), 32'd0);
    req1 = 4'b1100; ack1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_gnt1", 32'(gnt1), 32'h4);
    chk("post_rst_enc1", 32'(enc1), 32'd2);
    chk("post_rst_vld1", 32'(vld1), 32'd1);
    req1 = '0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
